btb_bimodal_predictor: RTL
==========================

Name: btb_bimodal_predictor

Overview:
- Fetch-stage branch predictor combining a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and a static backward-taken/forward-not-taken (BTFN) fallback.
- Consumes the fetch-side lookup signals and supplies predict_taken/target_addr to the fetch PC mux.
- Trained by the execute stage when a branch resolves, and keeps misprediction statistics.

Parameters:
- ENTRIES, 16: number of BTB/counter entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- CNT_INIT, 2'b01: counter value after reset (weakly not-taken).
- ALLOC_CNT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- current_pc  in  32  fetch PC being looked up
- is_branch  in  1  fetched instruction is a conditional branch
- is_rv32c  in  1  fetched instruction is 16-bit
- imm_sb  in  13  B-type immediate of the fetched instruction
- update_predictor  in  1  resolved branch update strobe from execute
- pc_to_update  in  32  PC of the resolved branch
- branch_result  in  1  1 = resolved taken
- prediction  in  1  prediction that was made for the resolved branch
- update_addr  in  32  resolved taken target
- predict_taken  out  1  redirect fetch to target_addr
- target_addr  out  32  predicted next PC
- mispredict_cnt  out  32  saturating count of mispredicted updates
- update_cnt  out  32  saturating count of all updates

Behaviour:
- Index and tag: index = pc[IDX_W:1]; tag = pc[31:IDX_W+1]. Bit 0 is ignored.
- Entry state: valid, tag, target[31:0], cnt[1:0].
- Lookup is combinational, 0-cycle, using the registered table state.
- A lookup hits when valid[idx] is set and the stored tag equals the current_pc tag.
- Prediction priority:
  1. RST high: predict_taken=0, target_addr = current_pc + (is_rv32c ? 2 : 4).
  2. !is_branch: predict_taken=0, target_addr = fall-through.
  3. is_branch and hit: predict_taken = cnt[1]. target_addr = BTB target if cnt[1], otherwise fall-through.
  4. is_branch and miss: predict_taken = imm_sb[12] (backward branch). target_addr = current_pc + sext32(imm_sb) if taken, otherwise fall-through.
- Address arithmetic is modulo 2^32; wrap-around is silent.
- Update is applied at the rising edge of CLK when update_predictor=1, using the pc_to_update index and tag:
  - Hit, taken: cnt = min(cnt+1, 3); target = update_addr.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate, overwriting any entry at that index. valid=1, tag, target=update_addr, cnt=ALLOC_CNT.
  - Miss, not taken: no table change.
- Statistics: each update increments update_cnt. An update with prediction != branch_result also increments mispredict_cnt. Both saturate at 32'hFFFF_FFFF.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update state. The new state is visible on the next cycle.
- Reset (synchronous, any cycle, including mid-update):
  - All valid=0, all cnt=CNT_INIT, both statistics counters = 0.
  - Stored tag and target are don't-care.
  - An update_predictor asserted in the same cycle as RST is discarded.
- No stall or handshake: every update strobe is consumed in one cycle; back-to-back updates on consecutive cycles are legal.

Test Plan:
- Reset, then current_pc=0x100, is_branch=1, imm_sb=13'h1FF8 (-8) -> predict_taken=1, target_addr=0xF8. Same with imm_sb=0x010 -> predict_taken=0, target_addr=0x104; with is_rv32c=1 -> target_addr=0x102.
- One update {pc_to_update=0x200, taken, update_addr=0x400}. Next-cycle lookup at 0x200 with is_branch=1 -> predict_taken=1, target 0x400. Two not-taken updates -> cnt=00, predict_taken=0, target 0x204.
- Four taken updates on one entry -> cnt saturates at 11. One not-taken update -> still predicts taken.
- Alias with ENTRIES=16: allocate 0x200, then a taken update at 0x220 (same index, different tag) evicts it. Lookup 0x200 falls back to BTFN; lookup 0x220 hits.
- Update and lookup of 0x300 in the same cycle -> lookup shows miss/static. Next cycle -> hit.
- Ten updates with prediction != branch_result on 3 of them -> update_cnt=10, mispredict_cnt=3. Assert RST together with an update -> both counters 0 and the entry is not allocated.

Source files
------------

// File: rtl/btb_bimodal_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters
// and a backward-taken/forward-not-taken fallback on BTB misses.
module btb_bimodal_predictor #(
  parameter int unsigned ENTRIES   = 16,
  parameter logic [1:0]  CNT_INIT  = 2'b01,
  parameter logic [1:0]  ALLOC_CNT = 2'b10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] current_pc,
  input  logic        is_branch,
  input  logic        is_rv32c,
  input  logic [12:0] imm_sb,
  input  logic        update_predictor,
  input  logic [31:0] pc_to_update,
  input  logic        branch_result,
  input  logic        prediction,
  input  logic [31:0] update_addr,
  output logic        predict_taken,
  output logic [31:0] target_addr,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] update_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 31 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [31:0]        mispredict_cnt_q;
  logic [31:0]        update_cnt_q;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [31:0]      fall_through;
  logic [31:0]      static_target;

  assign lk_idx        = current_pc[IDX_W:1];
  assign lk_tag        = current_pc[31:IDX_W+1];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign fall_through  = current_pc + (is_rv32c ? 32'd2 : 32'd4);
  assign static_target = current_pc + {{19{imm_sb[12]}}, imm_sb};

  always_comb begin
    predict_taken = 1'b0;
    target_addr   = fall_through;
    if (!RST && is_branch) begin
      if (lk_hit) begin
        predict_taken = cnt_q[lk_idx][1];
        if (cnt_q[lk_idx][1]) target_addr = target_q[lk_idx];
      end else begin
        // Backward branches (negative offset) are assumed to be loops.
        predict_taken = imm_sb[12];
        if (imm_sb[12]) target_addr = static_target;
      end
    end
  end

  // Update side
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign up_idx = pc_to_update[IDX_W:1];
  assign up_tag = pc_to_update[31:IDX_W+1];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Tag and target are deliberately left unreset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q          <= '0;
      mispredict_cnt_q <= '0;
      update_cnt_q     <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (update_predictor) begin
      if (up_hit) begin
        if (branch_result) begin
          target_q[up_idx] <= update_addr;
          if (cnt_q[up_idx] != 2'b11) cnt_q[up_idx] <= cnt_q[up_idx] + 2'd1;
        end else begin
          if (cnt_q[up_idx] != 2'b00) cnt_q[up_idx] <= cnt_q[up_idx] - 2'd1;
        end
      end else if (branch_result) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_addr;
        cnt_q[up_idx]    <= ALLOC_CNT;
      end
      if (update_cnt_q != '1) update_cnt_q <= update_cnt_q + 32'd1;
      if ((prediction != branch_result) && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign mispredict_cnt = mispredict_cnt_q;
  assign update_cnt     = update_cnt_q;

endmodule
